// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants for the ALU operation sequencer: ALU control codes,
// LEGv8 opcode fields and the sequencer state encoding.
package alu_op_sequencer_pkg;

  localparam int DATA_W = 64;
  localparam int OPC_W  = 11;
  localparam int CTRL_W = 4;
  localparam int CNT_W  = 16;

  localparam logic [CTRL_W-1:0] ALU_AND   = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR    = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD   = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SUB   = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_PASSB = 4'b0111;

  localparam logic [OPC_W-1:0] OP_ADD  = 11'b10001011000;
  localparam logic [OPC_W-1:0] OP_SUB  = 11'b11001011000;
  localparam logic [OPC_W-1:0] OP_AND  = 11'b10001010000;
  localparam logic [OPC_W-1:0] OP_ORR  = 11'b10101010000;
  localparam logic [OPC_W-1:0] OP_LDUR = 11'b11111000010;
  localparam logic [OPC_W-1:0] OP_STUR = 11'b11111000000;
  // CBZ carries a 3-bit don't-care tail, so only the upper 8 bits are matched.
  localparam logic [7:0]       OP_CBZ_PREFIX = 8'b10110100;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } seq_state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational LEGv8 opcode to ALU-control decoder; flags anything it
// does not recognise as illegal.
module alu_ctrl_decode
  import alu_op_sequencer_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  output logic [CTRL_W-1:0] ctrl,
  output logic              illegal
);

  always_comb begin
    ctrl    = ALU_AND;
    illegal = 1'b0;
    if (opcode[OPC_W-1:3] == OP_CBZ_PREFIX) begin
      ctrl = ALU_PASSB;
    end else begin
      case (opcode)
        OP_ADD:  ctrl = ALU_ADD;
        OP_SUB:  ctrl = ALU_SUB;
        OP_AND:  ctrl = ALU_AND;
        OP_ORR:  ctrl = ALU_OR;
        OP_LDUR: ctrl = ALU_ADD;
        OP_STUR: ctrl = ALU_ADD;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Request/response sequencer that issues one decoded operation at a time
// to an external ALU and returns its result with a saturating op counter.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
(
  input  logic              CLK,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [OPC_W-1:0]  ReqOpcode,
  input  logic [DATA_W-1:0] ReqA,
  input  logic [DATA_W-1:0] ReqB,
  output logic [DATA_W-1:0] AluBusA,
  output logic [DATA_W-1:0] AluBusB,
  output logic [CTRL_W-1:0] AluCtrl,
  input  logic [DATA_W-1:0] AluBusW,
  input  logic              AluZero,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspResult,
  output logic              RspZero,
  output logic              RspIllegal,
  output logic [CNT_W-1:0]  OpCount
);

  seq_state_t        state;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_illegal;
  logic [DATA_W-1:0] bus_a;
  logic [DATA_W-1:0] bus_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [CNT_W-1:0]  op_count;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal;

  alu_ctrl_decode u_decode (
    .opcode  (ReqOpcode),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // Illegal opcodes skip EXEC and leave the ALU control bus untouched so the
  // external ALU never sees a spurious operation change.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
      bus_a       <= '0;
      bus_b       <= '0;
      alu_ctrl    <= ALU_AND;
      op_count    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ReqValid) begin
            bus_a     <= ReqA;
            bus_b     <= ReqB;
            req_ready <= 1'b0;
            if (dec_illegal) begin
              rsp_result  <= '0;
              rsp_zero    <= 1'b0;
              rsp_illegal <= 1'b1;
              rsp_valid   <= 1'b1;
              state       <= ST_RESP;
            end else begin
              alu_ctrl <= dec_ctrl;
              state    <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          rsp_result  <= AluBusW;
          rsp_zero    <= AluZero;
          rsp_illegal <= 1'b0;
          rsp_valid   <= 1'b1;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (RspReady && rsp_valid) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
            if (op_count != CNT_MAX) begin
              op_count <= op_count + 16'd1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ReqReady   = req_ready;
  assign RspValid   = rsp_valid;
  assign RspResult  = rsp_result;
  assign RspZero    = rsp_zero;
  assign RspIllegal = rsp_illegal;
  assign AluBusA    = bus_a;
  assign AluBusB    = bus_b;
  assign AluCtrl    = alu_ctrl;
  assign OpCount    = op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU attached to
// the ALU buses; expected values are hand-computed constants.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_opcode;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [63:0] alu_w;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_illegal;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer dut (
    .CLK        (clk),
    .Reset      (rst),
    .ReqValid   (req_valid),
    .ReqReady   (req_ready),
    .ReqOpcode  (req_opcode),
    .ReqA       (req_a),
    .ReqB       (req_b),
    .AluBusA    (alu_a),
    .AluBusB    (alu_b),
    .AluCtrl    (alu_ctrl),
    .AluBusW    (alu_w),
    .AluZero    (alu_zero),
    .RspValid   (rsp_valid),
    .RspReady   (rsp_ready),
    .RspResult  (rsp_result),
    .RspZero    (rsp_zero),
    .RspIllegal (rsp_illegal),
    .OpCount    (op_count)
  );

  // Behavioural external ALU.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_w = alu_a & alu_b;
      4'b0001: alu_w = alu_a | alu_b;
      4'b0010: alu_w = alu_a + alu_b;
      4'b0110: alu_w = alu_a - alu_b;
      4'b0111: alu_w = alu_b;
      default: alu_w = 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
    alu_zero = (alu_w == 64'd0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b);
    req_valid  = 1'b1;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
  endtask

  // Legal op with rsp_ready held high: request driven after edge N,
  // EXEC after N+1, response after N+2, handshake at N+3.
  task automatic run_legal(input string tag, input logic [10:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [3:0] exp_ctrl,
                           input logic [63:0] exp_res, input logic exp_zero,
                           input logic [15:0] exp_cnt);
    apply_stimulus(op, a, b);
    tick();
    req_valid = 1'b0;
    check_output({tag, "_exec_ready"}, req_ready, 1'b0);
    check_output({tag, "_exec_ctrl"}, alu_ctrl, exp_ctrl);
    check_output({tag, "_exec_busa"}, alu_a, a);
    check_output({tag, "_exec_busb"}, alu_b, b);
    check_output({tag, "_exec_valid"}, rsp_valid, 1'b0);
    tick();
    check_output({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    check_output({tag, "_rsp_result"}, rsp_result, exp_res);
    check_output({tag, "_rsp_zero"}, rsp_zero, exp_zero);
    check_output({tag, "_rsp_illegal"}, rsp_illegal, 1'b0);
    tick();
    check_output({tag, "_done_valid"}, rsp_valid, 1'b0);
    check_output({tag, "_done_ready"}, req_ready, 1'b1);
    check_output({tag, "_done_count"}, op_count, exp_cnt);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_ready"}, req_ready, 1'b1);
    check_output({tag, "_valid"}, rsp_valid, 1'b0);
    check_output({tag, "_result"}, rsp_result, 64'd0);
    check_output({tag, "_zero"}, rsp_zero, 1'b0);
    check_output({tag, "_illegal"}, rsp_illegal, 1'b0);
    check_output({tag, "_busa"}, alu_a, 64'd0);
    check_output({tag, "_busb"}, alu_b, 64'd0);
    check_output({tag, "_ctrl"}, alu_ctrl, 4'b0000);
    check_output({tag, "_count"}, op_count, 16'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_opcode = 11'd0;
    req_a      = 64'd0;
    req_b      = 64'd0;
    rsp_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_reset_values("reset");

    rsp_ready = 1'b1;
    run_legal("add",  11'b10001011000, 64'd5, 64'd7, 4'b0010, 64'd12, 1'b0, 16'd1);
    run_legal("sub",  11'b11001011000, 64'h1234, 64'h1234, 4'b0110, 64'd0, 1'b1, 16'd2);
    run_legal("cbz",  11'b10110100101, 64'd99, 64'd0, 4'b0111, 64'd0, 1'b1, 16'd3);
    run_legal("and",  11'b10001010000, 64'hF0F0, 64'hFF00, 4'b0000, 64'hF000, 1'b0, 16'd4);
    run_legal("orr",  11'b10101010000, 64'hF0F0, 64'hFF00, 4'b0001, 64'hFFF0, 1'b0, 16'd5);
    run_legal("ldur", 11'b11111000010, 64'd100, 64'd8, 4'b0010, 64'd108, 1'b0, 16'd6);
    run_legal("stur", 11'b11111000000, 64'd200, 64'd16, 4'b0010, 64'd216, 1'b0, 16'd7);

    $display("[TB] illegal opcode");
    apply_stimulus(11'b00000000000, 64'd1, 64'd2);
    tick();
    req_valid = 1'b0;
    check_output("ill_valid", rsp_valid, 1'b1);
    check_output("ill_flag", rsp_illegal, 1'b1);
    check_output("ill_result", rsp_result, 64'd0);
    check_output("ill_zero", rsp_zero, 1'b0);
    check_output("ill_ctrl", alu_ctrl, 4'b0010);
    tick();
    check_output("ill_done_valid", rsp_valid, 1'b0);
    check_output("ill_done_count", op_count, 16'd8);

    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    apply_stimulus(11'b10001011000, 64'd3, 64'd4);
    tick();
    req_valid = 1'b0;
    tick();
    check_output("bp_valid0", rsp_valid, 1'b1);
    apply_stimulus(11'b10101010000, 64'd1, 64'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("bp_hold_valid", rsp_valid, 1'b1);
      check_output("bp_hold_result", rsp_result, 64'd7);
      check_output("bp_hold_ready", req_ready, 1'b0);
      check_output("bp_hold_busa", alu_a, 64'd3);
      check_output("bp_hold_count", op_count, 16'd8);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check_output("bp_release_valid", rsp_valid, 1'b0);
    check_output("bp_release_count", op_count, 16'd9);
    tick();
    check_output("bp_idle_count", op_count, 16'd9);
    check_output("bp_idle_busa", alu_a, 64'd3);

    $display("[TB] reset during EXEC");
    apply_stimulus(11'b10001011000, 64'd1, 64'd1);
    tick();
    req_valid = 1'b0;
    check_output("rst_pre_ctrl", alu_ctrl, 4'b0010);
    rst = 1'b1;
    #1;
    check_reset_values("rst_mid");
    #2;
    rst = 1'b0;
    tick();
    tick();
    check_reset_values("rst_after");

    $display("[TB] counter saturation");
    force dut.op_count = 16'hFFFE;
    #1;
    release dut.op_count;
    #1;
    check_output("sat_preload", op_count, 16'hFFFE);
    tick();
    apply_stimulus(11'b00000000000, 64'd0, 64'd0);
    tick();
    req_valid = 1'b0;
    tick();
    check_output("sat_first", op_count, 16'hFFFF);
    apply_stimulus(11'b00000000000, 64'd0, 64'd0);
    tick();
    req_valid = 1'b0;
    check_output("sat_valid", rsp_valid, 1'b1);
    tick();
    check_output("sat_hold", op_count, 16'hFFFF);
    check_output("sat_done_valid", rsp_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous active-high reset.
REQ-004 ReqValid  input  1  request present; ReqReady  output  1  block can accept.
REQ-005 ReqOpcode  input  11  LEGv8 opcode field [31:21].
REQ-006 ReqA, ReqB  input  64 each  request operands.
REQ-007 AluBusA, AluBusB  output  64 each  operands driven to the external ALU.
REQ-008 AluCtrl  output  4  ALU operation select.
REQ-009 AluBusW  input  64  ALU result; AluZero  input  1  ALU zero flag.
REQ-010 RspValid  output  1  response present; RspReady  input  1  consumer accepts.
REQ-011 RspResult  output  64  result; RspZero  output  1  zero flag; RspIllegal  output  1  opcode not decoded.
REQ-012 OpCount  output  16  count of completed responses.

Function
REQ-013 Decode SHALL be: ADD 10001011000 -> 0010; SUB 11001011000 -> 0110; AND 10001010000 -> 0000; ORR 10101010000 -> 0001; LDUR 11111000010 -> 0010; STUR 11111000000 -> 0010; CBZ 10110100xxx -> 0111 (PassB); all else illegal.
REQ-014 FSM states SHALL be IDLE, EXEC, RESP.
REQ-015 IDLE: ReqReady=1, RspValid=0; ReqValid=1 at edge captures opcode, ReqA, ReqB, decoded ctrl; legal -> EXEC, illegal -> RESP.
REQ-016 ReqReady SHALL be 1 only in IDLE; requests presented in EXEC/RESP SHALL be ignored and not lost from the requester's view (requester holds).
REQ-017 EXEC: exactly one cycle; AluBusA/AluBusB/AluCtrl driven from captured registers; at the closing edge AluBusW and AluZero SHALL be registered into RspResult/RspZero, RspIllegal=0, -> RESP.
REQ-018 Illegal path: RspResult=0, RspZero=0, RspIllegal=1, AluCtrl unchanged from previous value.
REQ-019 RESP: RspValid=1, RspResult/RspZero/RspIllegal stable until handshake; RspReady=1 at edge -> IDLE and OpCount increments.
REQ-020 Latency: legal request accepted at edge N SHALL give RspValid=1 after edge N+2; illegal after edge N+1.
REQ-021 Throughput: no new request accepted in the cycle a response completes (back-to-back spacing of 3 cycles legal, 2 illegal).
REQ-022 AluBusA/AluBusB/AluCtrl SHALL hold last captured values outside EXEC (no glitching to zero).
REQ-023 OpCount SHALL saturate at 16'hFFFF; illegal responses also count.
REQ-024 RspReady asserted while RspValid=0 SHALL have no effect.

Reset
REQ-025 Reset SHALL force state IDLE, ReqReady=1 after release, RspValid=0, RspResult=0, RspZero=0, RspIllegal=0, AluBusA=0, AluBusB=0, AluCtrl=4'b0000, OpCount=0.
REQ-026 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response and no count.

Structure
REQ-027 A shared package SHALL hold ALUCtrl constants (AND 0000, OR 0001, ADD 0010, SUB 0110, PassB 0111), the LEGv8 opcode constants, and the state encoding.
REQ-028 Decode SHALL live in one combinational sub-module alu_ctrl_decode (opcode in, 4-bit ctrl plus illegal out), reusable by the datapath control.

Verification
REQ-029 ADD, A=5, B=7, ALU model connected, RspReady=1 -> AluCtrl=0010 in EXEC, RspValid after edge N+2, RspResult=12, RspZero=0, OpCount=1.
REQ-030 SUB, A=B=64'h1234 -> RspResult=0, RspZero=1; CBZ 10110100101, B=0 -> AluCtrl=0111, RspZero=1.
REQ-031 Opcode 00000000000 -> RspValid after edge N+1, RspIllegal=1, RspResult=0, AluCtrl unchanged.
REQ-032 RspReady held 0 for 5 cycles -> RspValid and RspResult stable, ReqReady=0, second ReqValid not accepted; release -> OpCount increments once.
REQ-033 Reset pulse mid-EXEC -> all outputs at REQ-025 values, no response emitted, OpCount=0.
REQ-034 OpCount preloaded via 65535 completions (or forced) -> further completion leaves 16'hFFFF.
